// File: rtl/data_ram_responder.sv
// Responder for the CPU data-memory bus: 15-word storage with a memory-mapped I/O port and a post-reset clear sweep.
// Optional build macro: DATA_RAM_BYPASS_EN (write-first forwarding of datain onto dataout).
module data_ram_responder #(
  parameter int                    data_width = 4,
  parameter int                    addr_width = 4,
  parameter int                    io_addr    = 2**addr_width - 1,
  parameter logic [data_width-1:0] init_val   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rw,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] datain,
  output logic [data_width-1:0] dataout,
  input  logic [data_width-1:0] io_in,
  output logic [data_width-1:0] io_out,
  output logic                  busy,
  output logic                  dbg_state
);

  localparam int                    DEPTH    = 2**addr_width - 1;
  localparam logic [addr_width-1:0] IO_ADDR  = addr_width'(io_addr);
  localparam logic [addr_width-1:0] LAST_PTR = addr_width'(io_addr - 1);
  localparam logic [addr_width:0]   DEPTH_W  = (addr_width + 1)'(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q,   state_d;
  logic [addr_width-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    busy_q,    busy_d;
  logic [data_width-1:0]   dataout_q, dataout_d;
  logic [data_width-1:0]   io_out_q,  io_out_d;
  logic [data_width-1:0]   io_meta_q, io_meta_d;
  logic [data_width-1:0]   io_sync_q, io_sync_d;

  logic [data_width-1:0]   mem_q [0:DEPTH-1];
  logic                    mem_we;
  logic [addr_width-1:0]   mem_waddr;
  logic [data_width-1:0]   mem_wdata;

  logic                    is_io;
  logic                    in_range;
  logic [data_width-1:0]   read_word;

  assign is_io     = (addr == IO_ADDR);
  assign in_range  = ({1'b0, addr} < DEPTH_W);
  assign read_word = in_range ? mem_q[addr] : '0;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    dataout_d = dataout_q;
    io_out_d  = io_out_q;
    io_meta_d = io_in;
    io_sync_d = io_meta_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = datain;

    case (state_q)
      CLEAR: begin
        // Bus inputs are ignored; the sweep owns the write port.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = init_val;
        dataout_d = '0;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = READY;
          busy_d  = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + addr_width'(1);
        end
      end

      READY: begin
        dataout_d = is_io ? io_sync_q : read_word;
        if (rw) begin
          if (is_io) begin
            io_out_d = datain;
          end else if (in_range) begin
            mem_we = 1'b1;
          end
`ifdef DATA_RAM_BYPASS_EN
          dataout_d = datain;
`endif
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      dataout_q <= '0;
      io_out_q  <= '0;
      io_meta_q <= '0;
      io_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      dataout_q <= dataout_d;
      io_out_q  <= io_out_d;
      io_meta_q <= io_meta_d;
      io_sync_q <= io_sync_d;
    end
  end

  // Storage has no reset; the sweep provides the known contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dataout   = dataout_q;
  assign io_out    = io_out_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed, table-driven bench for data_ram_responder: reset sweep, load/store, I/O port, reset abort.
module tb_data_ram_responder;

`ifdef DATA_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rw;
  logic [3:0] addr;
  logic [3:0] datain;
  logic [3:0] dataout;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       busy;
  logic       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  data_ram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .rw        (rw),
    .addr      (addr),
    .datain    (datain),
    .dataout   (dataout),
    .io_in     (io_in),
    .io_out    (io_out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rw;
    logic [3:0] addr;
    logic [3:0] datain;
    logic [3:0] io_in;
    logic [3:0] exp_dout;
    logic [3:0] exp_io;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] d, input logic [3:0] io);
    @(negedge clk);
    rw     = r;
    addr   = a;
    datain = d;
    io_in  = io;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_checks(input string tag);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_busy"}, busy, (i < 15) ? 1 : 0);
      check({tag, "_dout"}, dataout, 0);
      check({tag, "_ioout"}, io_out, 0);
    end
  endtask

  initial begin
    // Vectors applied in READY, one per cycle, in order.
    vecs[0]  = '{1'b0, 4'd3,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 4'd5,  4'hA, 4'h0, BYP ? 4'hA : 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 4'd5,  4'h0, 4'h0, 4'hA, 4'h0};
    vecs[3]  = '{1'b0, 4'd6,  4'h0, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{1'b1, 4'd15, 4'h6, 4'h0, BYP ? 4'h6 : 4'h0, 4'h6};
    vecs[5]  = '{1'b0, 4'd15, 4'h0, 4'h0, 4'h0, 4'h6};
    vecs[6]  = '{1'b0, 4'd14, 4'h0, 4'h0, 4'h0, 4'h6};
    vecs[7]  = '{1'b1, 4'd2,  4'h3, 4'h0, BYP ? 4'h3 : 4'h0, 4'h6};
    vecs[8]  = '{1'b1, 4'd2,  4'hC, 4'h0, BYP ? 4'hC : 4'h3, 4'h6};
    vecs[9]  = '{1'b0, 4'd2,  4'h0, 4'h0, 4'hC, 4'h6};
    vecs[10] = '{1'b0, 4'd15, 4'h0, 4'h9, 4'h0, 4'h6};
    vecs[11] = '{1'b0, 4'd15, 4'h0, 4'h9, 4'h0, 4'h6};
    vecs[12] = '{1'b0, 4'd15, 4'h0, 4'h9, 4'h9, 4'h6};
    vecs[13] = '{1'b1, 4'd0,  4'h7, 4'h9, BYP ? 4'h7 : 4'h0, 4'h6};
    vecs[14] = '{1'b0, 4'd0,  4'h0, 4'h9, 4'h7, 4'h6};
    vecs[15] = '{1'b1, 4'd14, 4'hF, 4'h9, BYP ? 4'hF : 4'h0, 4'h6};
    vecs[16] = '{1'b0, 4'd14, 4'h0, 4'h9, 4'hF, 4'h6};
    vecs[17] = '{1'b0, 4'd5,  4'h0, 4'h9, 4'hA, 4'h6};

    rst    = 1'b0;
    rw     = 1'b0;
    addr   = 4'd0;
    datain = 4'd0;
    io_in  = 4'd0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1);
    check("reset_dout", dataout, 0);
    check("reset_ioout", io_out, 0);
    check("reset_state", dbg_state, 0);

    @(negedge clk);
    rst  = 1'b1;
    addr = 4'd3;
    sweep_checks("sweep1");
    check("ready_state", dbg_state, 1);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rw, vecs[i].addr, vecs[i].datain, vecs[i].io_in);
      check($sformatf("vec%0d_dout", i), dataout, vecs[i].exp_dout);
      check($sformatf("vec%0d_ioout", i), io_out, vecs[i].exp_io);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Reset pulse in the middle of a high clock phase
    @(posedge clk);
    #3;
    check("pre_rst_dout", dataout, 4'hA);
    rst = 1'b0;
    #1;
    check("midrst_dout", dataout, 0);
    check("midrst_ioout", io_out, 0);
    check("midrst_busy", busy, 1);

    @(negedge clk);
    rst    = 1'b1;
    rw     = 1'b1;
    addr   = 4'd5;
    datain = 4'hB;
    sweep_checks("sweep2");

    drive(1'b0, 4'd5, 4'h0, 4'h9);
    check("post_rst_mem5", dataout, 0);
    drive(1'b0, 4'd14, 4'h0, 4'h9);
    check("post_rst_mem14", dataout, 0);
    drive(1'b0, 4'd15, 4'h0, 4'h9);
    check("post_rst_io", dataout, 4'h9);
    drive(1'b1, 4'd5, 4'hB, 4'h9);
    drive(1'b0, 4'd5, 4'h0, 4'h9);
    check("post_rst_store", dataout, 4'hB);
    check("post_rst_ioout", io_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
